// File: rtl/riscv_mdu_pkg.sv
// Shared definitions for the RV32M multiply/divide unit: funct3 encodings,
// divider FSM states and special-case result constants.
package riscv_mdu_pkg;

  localparam logic [2:0] FUNCT3_DIV  = 3'b100;
  localparam logic [2:0] FUNCT3_DIVU = 3'b101;
  localparam logic [2:0] FUNCT3_REM  = 3'b110;
  localparam logic [2:0] FUNCT3_REMU = 3'b111;

  localparam logic [31:0] DIV_OVF_DIVIDEND = 32'h8000_0000;
  localparam logic [31:0] DIV_ALL_ONES     = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StFixup,
    StDone
  } div_state_e;

  // Magnitude of v when it is treated as signed, raw value otherwise.
  function automatic logic [31:0] abs_if_signed(logic [31:0] v, logic is_signed);
    return (is_signed && v[31]) ? -v : v;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract step: shift the next dividend bit into the
// partial remainder and subtract the divisor if it fits.
module div_step #(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN:0]   rem_prev,
  input  logic            dividend_bit,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN:0]   rem_next,
  output logic            quot_bit
);

  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;

  // The incoming remainder is always below the divisor, so its MSB is zero.
  logic unused_rem_msb;
  assign unused_rem_msb = rem_prev[XLEN];

  // Trial subtraction; keep the difference only when it does not go negative.
  always_comb begin
    shifted  = {rem_prev[XLEN-1:0], dividend_bit};
    diff     = shifted - {1'b0, divisor};
    quot_bit = (shifted >= {1'b0, divisor});
    rem_next = quot_bit ? diff : shifted;
  end

endmodule

// File: rtl/div_unit_iterative.sv
// Iterative RV32M DIV/DIVU/REM/REMU unit with a valid/ready handshake.
// Operands are converted to magnitudes on accept, BITS_PER_CYCLE restoring
// steps run per CALC cycle, and signs and special cases are applied in FIXUP.
// Optional: define DIV_SPECIAL_FASTPATH_EN to send divide-by-zero and signed
// overflow straight from IDLE to FIXUP, skipping CALC.
module div_unit_iterative
  import riscv_mdu_pkg::*;
#(
  parameter int unsigned BITS_PER_CYCLE = 1,
  parameter int unsigned XLEN           = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [2:0]      i_funct3,
  input  logic [XLEN-1:0] i_rs1,
  input  logic [XLEN-1:0] i_rs2,
  input  logic            i_kill,
  output logic            o_valid,
  output logic [XLEN-1:0] o_result
);

  localparam int unsigned Steps = XLEN / BITS_PER_CYCLE;
  localparam int unsigned CntW  = $clog2(Steps);
  localparam logic [CntW-1:0] LastCnt = CntW'(Steps - 1);

  if (XLEN != 32) begin : g_bad_xlen
    $error("div_unit_iterative: only XLEN=32 is supported");
  end
  if (BITS_PER_CYCLE != 1 && BITS_PER_CYCLE != 2 && BITS_PER_CYCLE != 4) begin : g_bad_bpc
    $error("div_unit_iterative: BITS_PER_CYCLE must be 1, 2 or 4");
  end

  div_state_e      state_q;
  logic [2:0]      funct3_q;
  logic            signed_q;
  logic            q_neg_q;
  logic            r_neg_q;
  logic            dbz_q;
  logic            ovf_q;
  logic [XLEN-1:0] rs1_q;
  logic [XLEN-1:0] divisor_q;
  logic [XLEN-1:0] dq_q;     // dividend bits shift out the top, quotient bits in the bottom
  logic [XLEN:0]   rem_q;
  logic [CntW-1:0] cnt_q;

  logic            accept;
  logic [2:0]      f3_eff;
  logic            in_signed;
  logic            in_dbz;
  logic            in_ovf;
  logic            is_rem;
  logic [XLEN-1:0] fix_result;

  logic [XLEN:0]           chain_rem [BITS_PER_CYCLE+1];
  logic [BITS_PER_CYCLE-1:0] q_bits;

  assign o_ready = (state_q == StIdle);
  assign accept  = i_valid & o_ready & ~i_kill;

  // Decode the request; an illegal funct3 (bit 2 clear) is executed as DIVU.
  always_comb begin
    f3_eff    = i_funct3[2] ? i_funct3 : FUNCT3_DIVU;
    in_signed = (f3_eff == FUNCT3_DIV) || (f3_eff == FUNCT3_REM);
    in_dbz    = (i_rs2 == '0);
    in_ovf    = in_signed && (i_rs1 == DIV_OVF_DIVIDEND) && (i_rs2 == DIV_ALL_ONES);
  end

  // Chain of restoring steps evaluated in one CALC cycle.
  assign chain_rem[0] = rem_q;
  for (genvar k = 0; k < BITS_PER_CYCLE; k++) begin : g_step
    div_step #(
      .XLEN(XLEN)
    ) u_div_step (
      .rem_prev    (chain_rem[k]),
      .dividend_bit(dq_q[XLEN-1-k]),
      .divisor     (divisor_q),
      .rem_next    (chain_rem[k+1]),
      .quot_bit    (q_bits[BITS_PER_CYCLE-1-k])
    );
  end

  // Sign correction and special-case override of the raw quotient/remainder.
  always_comb begin
    is_rem     = (funct3_q == FUNCT3_REM) || (funct3_q == FUNCT3_REMU);
    fix_result = '0;
    if (dbz_q) begin
      fix_result = is_rem ? rs1_q : DIV_ALL_ONES;
    end else if (ovf_q) begin
      fix_result = is_rem ? '0 : DIV_OVF_DIVIDEND;
    end else if (is_rem) begin
      fix_result = (signed_q && r_neg_q) ? -rem_q[XLEN-1:0] : rem_q[XLEN-1:0];
    end else begin
      fix_result = (signed_q && q_neg_q) ? -dq_q : dq_q;
    end
  end

  // Divider FSM with registered datapath and outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      funct3_q  <= '0;
      signed_q  <= 1'b0;
      q_neg_q   <= 1'b0;
      r_neg_q   <= 1'b0;
      dbz_q     <= 1'b0;
      ovf_q     <= 1'b0;
      rs1_q     <= '0;
      divisor_q <= '0;
      dq_q      <= '0;
      rem_q     <= '0;
      cnt_q     <= '0;
      o_valid   <= 1'b0;
      o_result  <= '0;
    end else begin
      o_valid <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            funct3_q  <= f3_eff;
            signed_q  <= in_signed;
            q_neg_q   <= i_rs1[XLEN-1] ^ i_rs2[XLEN-1];
            r_neg_q   <= i_rs1[XLEN-1];
            dbz_q     <= in_dbz;
            ovf_q     <= in_ovf;
            rs1_q     <= i_rs1;
            divisor_q <= abs_if_signed(i_rs2, in_signed);
            dq_q      <= abs_if_signed(i_rs1, in_signed);
            rem_q     <= '0;
            cnt_q     <= '0;
`ifdef DIV_SPECIAL_FASTPATH_EN
            state_q   <= (in_dbz || in_ovf) ? StFixup : StCalc;
`else
            state_q   <= StCalc;
`endif
          end
        end
        StCalc: begin
          if (i_kill) begin
            state_q <= StIdle;
          end else begin
            rem_q <= chain_rem[BITS_PER_CYCLE];
            dq_q  <= {dq_q[XLEN-1-BITS_PER_CYCLE:0], q_bits};
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == LastCnt) begin
              state_q <= StFixup;
            end
          end
        end
        StFixup: begin
          if (i_kill) begin
            state_q <= StIdle;
          end else begin
            o_result <= fix_result;
            o_valid  <= 1'b1;
            state_q  <= StDone;
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  a_legal_funct3: assert property (@(posedge clk) disable iff (rst) accept |-> i_funct3[2]);

endmodule

// File: tb/tb_div_unit_iterative.sv
// Scoreboard bench for div_unit_iterative: three instances (1, 2 and 4 bits
// per cycle), expected results queued on issue and checked by a monitor that
// watches o_valid. Latency of special cases follows DIV_SPECIAL_FASTPATH_EN.
module tb_div_unit_iterative;
  import riscv_mdu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  funct3;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic        vld  [3];
  logic        kill [3];
  logic        rdy  [3];
  logic        ovld [3];
  logic [31:0] res  [3];

  int cyc;
  int n_pass;
  int n_total;
  int n_valid;
  int op_tag;

  typedef struct {
    int          dut;
    logic [31:0] res;
    int          cyc;
    int          tag;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    div_unit_iterative #(
      .BITS_PER_CYCLE(1 << g),
      .XLEN          (32)
    ) u_dut (
      .clk     (clk),
      .rst     (rst),
      .i_valid (vld[g]),
      .o_ready (rdy[g]),
      .i_funct3(funct3),
      .i_rs1   (rs1),
      .i_rs2   (rs2),
      .i_kill  (kill[g]),
      .o_valid (ovld[g]),
      .o_result(res[g])
    );
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
  endtask

  // Cycles from the accepting edge to the o_valid cycle, minus one.
  function automatic int lat(int g, bit special);
`ifdef DIV_SPECIAL_FASTPATH_EN
    if (special) return 1;
`endif
    return (32 >> g) + 1;
  endfunction

  function automatic logic [31:0] model(logic [2:0] f, logic [31:0] a, logic [31:0] b);
    logic signed [31:0] sa = a;
    logic signed [31:0] sb = b;
    bit sgn = !f[0];
    bit rem = f[1];
    if (b == 0) return rem ? a : 32'hFFFF_FFFF;
    if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return rem ? 32'h0 : 32'h8000_0000;
    if (sgn) return rem ? 32'(sa % sb) : 32'(sa / sb);
    return rem ? a % b : a / b;
  endfunction

  // Monitor: every o_valid pops one expectation.
  always @(negedge clk) begin
    if (!rst) begin
      for (int g = 0; g < 3; g++) begin
        if (ovld[g]) begin
          n_valid++;
          if (exp_q.size() == 0) begin
            n_total++;
            $display("FAIL unexpected o_valid: dut %0d result 0x%08h, want no strobe", g, res[g]);
          end else begin
            mon_e = exp_q.pop_front();
            check($sformatf("op%0d dut", mon_e.tag), 32'(g), 32'(mon_e.dut));
            check($sformatf("op%0d result", mon_e.tag), res[g], mon_e.res);
            check($sformatf("op%0d valid cycle", mon_e.tag), cyc, mon_e.cyc);
          end
        end
      end
    end
  end

  task automatic step_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input int g, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] r, input bit special,
                       input bit push);
    int n = 0;
    while (!rdy[g] && n < 200) begin
      step_cycle();
      n++;
    end
    check("ready before issue", 32'(rdy[g]), 32'd1);
    funct3 = f;
    rs1    = a;
    rs2    = b;
    vld[g] = 1'b1;
    step_cycle();
    vld[g] = 1'b0;
    op_tag++;
    if (push) exp_q.push_back('{g, r, cyc + lat(g, special), op_tag});
  endtask

  task automatic wait_done(input int g, input int exp_busy);
    int busy = 0;
    while (!rdy[g] && busy < 200) begin
      busy++;
      step_cycle();
    end
    check($sformatf("op%0d busy cycles", op_tag), 32'(busy), 32'(exp_busy));
    check($sformatf("op%0d drained", op_tag), 32'(exp_q.size()), 32'd0);
  endtask

  task automatic run_op(input int g, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] r, input bit special);
    issue(g, f, a, b, r, special, 1'b1);
    wait_done(g, lat(g, special) + 1);
  endtask

  initial begin
    int acc;
    int n;
    int nv;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  f;
    bit          sp;

    rst    = 1'b1;
    funct3 = FUNCT3_DIVU;
    rs1    = '0;
    rs2    = '0;
    for (int g = 0; g < 3; g++) begin
      vld[g]  = 1'b0;
      kill[g] = 1'b0;
    end
    step_cycle();
    step_cycle();
    for (int g = 0; g < 3; g++) begin
      check($sformatf("reset dut%0d o_ready", g), 32'(rdy[g]), 32'd1);
      check($sformatf("reset dut%0d o_valid", g), 32'(ovld[g]), 32'd0);
      check($sformatf("reset dut%0d o_result", g), res[g], 32'h0);
    end
    rst = 1'b0;
    step_cycle();

    // Directed vectors on the 1-bit-per-cycle instance.
    run_op(0, FUNCT3_DIVU, 32'd100,       32'd7,         32'd14,        1'b0);
    run_op(0, FUNCT3_REMU, 32'd100,       32'd7,         32'd2,         1'b0);
    run_op(0, FUNCT3_DIV,  32'hFFFF_FF9C, 32'd7,         32'hFFFF_FFF2, 1'b0);
    run_op(0, FUNCT3_REM,  32'hFFFF_FF9C, 32'd7,         32'hFFFF_FFFE, 1'b0);
    run_op(0, FUNCT3_REM,  32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 1'b0);
    run_op(0, FUNCT3_DIV,  32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14,        1'b0);
    run_op(0, FUNCT3_DIV,  32'd100,       32'hFFFF_FFF9, 32'hFFFF_FFF2, 1'b0);
    run_op(0, FUNCT3_REM,  32'd100,       32'hFFFF_FFF9, 32'd2,         1'b0);
    run_op(0, FUNCT3_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1);
    run_op(0, FUNCT3_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         1'b1);
    run_op(0, FUNCT3_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         1'b0);
    run_op(0, FUNCT3_REMU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0);
    run_op(0, FUNCT3_DIV,  32'd5,         32'd0,         32'hFFFF_FFFF, 1'b1);
    run_op(0, FUNCT3_REM,  32'd5,         32'd0,         32'd5,         1'b1);
    run_op(0, FUNCT3_DIVU, 32'd5,         32'd0,         32'hFFFF_FFFF, 1'b1);
    run_op(0, FUNCT3_REMU, 32'd5,         32'd0,         32'd5,         1'b1);
    run_op(0, FUNCT3_REM,  32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 1'b1);
    run_op(0, FUNCT3_DIVU, 32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, 1'b0);
    run_op(0, FUNCT3_REMU, 32'hFFFF_FFFF, 32'h10,        32'hF,         1'b0);
    run_op(0, FUNCT3_DIV,  32'h8000_0000, 32'd1,         32'h8000_0000, 1'b0);
    run_op(0, FUNCT3_DIVU, 32'h1234_5678, 32'h1234,      32'h1_0004,    1'b0);
    run_op(0, FUNCT3_REMU, 32'h1234_5678, 32'h1234,      32'hDA8,       1'b0);
    run_op(0, FUNCT3_DIV,  32'd7,         32'd100,       32'h0,         1'b0);
    run_op(0, FUNCT3_REM,  32'hFFFF_FFF9, 32'd100,       32'hFFFF_FFF9, 1'b0);

    // Kill in CALC cycle 10: no strobe, idle next cycle, result held.
    nv = n_valid;
    issue(0, FUNCT3_DIVU, 32'd1000, 32'd3, 32'd0, 1'b0, 1'b0);
    repeat (9) step_cycle();
    kill[0] = 1'b1;
    step_cycle();
    kill[0] = 1'b0;
    check("kill o_ready", 32'(rdy[0]), 32'd1);
    repeat (40) step_cycle();
    check("kill no o_valid", 32'(n_valid), 32'(nv));
    check("kill o_result held", res[0], 32'hFFFF_FFF9);

    // Kill together with valid in IDLE is not an accept.
    funct3  = FUNCT3_DIVU;
    rs1     = 32'd50;
    rs2     = 32'd5;
    vld[0]  = 1'b1;
    kill[0] = 1'b1;
    step_cycle();
    vld[0]  = 1'b0;
    kill[0] = 1'b0;
    check("kill+valid no accept", 32'(rdy[0]), 32'd1);
    run_op(0, FUNCT3_DIVU, 32'd9, 32'd3, 32'd3, 1'b0);

    // i_valid held high with changing operands while busy.
    funct3 = FUNCT3_DIVU;
    rs1    = 32'd1000;
    rs2    = 32'd3;
    vld[0] = 1'b1;
    step_cycle();
    acc = cyc;
    op_tag++;
    exp_q.push_back('{0, 32'd333, acc + lat(0, 1'b0), op_tag});
    n = 0;
    while (!rdy[0] && n < 100) begin
      rs1    = 32'hDEAD_0000 + 32'(n);
      rs2    = 32'(n + 1);
      funct3 = n[0] ? FUNCT3_REM : FUNCT3_DIV;
      step_cycle();
      n++;
    end
    funct3 = FUNCT3_REMU;
    rs1    = 32'd1000;
    rs2    = 32'd7;
    step_cycle();
    vld[0] = 1'b0;
    check("back-to-back accept cycle", 32'(cyc - acc), 32'd35);
    op_tag++;
    exp_q.push_back('{0, 32'd6, cyc + lat(0, 1'b0), op_tag});
    wait_done(0, lat(0, 1'b0) + 1);

    // Reset during CALC.
    issue(0, FUNCT3_DIVU, 32'd1000, 32'd3, 32'd0, 1'b0, 1'b0);
    repeat (4) step_cycle();
    rst = 1'b1;
    step_cycle();
    check("rst o_valid", 32'(ovld[0]), 32'd0);
    check("rst o_result", res[0], 32'h0);
    check("rst o_ready", 32'(rdy[0]), 32'd1);
    rst = 1'b0;
    step_cycle();
    run_op(0, FUNCT3_DIVU, 32'd9, 32'd3, 32'd3, 1'b0);

    // Reference-model sweep on the 2- and 4-bit-per-cycle instances.
    for (int g = 1; g < 3; g++) begin
      for (int fi = 0; fi < 4; fi++) begin
        f = 3'b100 | 3'(fi);
        for (int i = 0; i < 50; i++) begin
          a = $urandom;
          b = $urandom;
          if (i == 0) b = 32'h0;
          else if (i == 1) begin
            a = 32'h8000_0000;
            b = 32'hFFFF_FFFF;
          end else if (i % 3 == 0) b = b >> $urandom_range(0, 31);
          else if (i % 3 == 1) a = a >> $urandom_range(0, 31);
          sp = (b == 0) || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
          run_op(g, f, a, b, model(f, a, b), sp);
        end
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d/%0d", n_pass, n_total);
    $fatal(1);
  end

endmodule
